// File: rtl/mac_acr.sv
// Accumulator register bank and flag unit behind the MAC datapath.
// Holds the E2 pipe stage, does result write-back and RF loads, and supplies bypassed operands.
module mac_acr #(
  parameter int NACR = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    iss_valid_i,
  input  logic                    iss_we_i,
  input  logic                    iss_fe_i,
  input  logic [$clog2(NACR)-1:0] iss_dst_i,
  input  logic [$clog2(NACR)-1:0] rda_idx_i,
  input  logic [$clog2(NACR)-1:0] rdb_idx_i,
  output logic [39:0]             mac_operanda_o,
  output logic [39:0]             mac_operandb_o,
  input  logic [39:0]             mac_result_i,
  input  logic                    sat_flag_i,
  input  logic                    scale_overflow_i,
  input  logic                    add_pos_overflow_i,
  input  logic                    add_neg_overflow_i,
  input  logic                    rf_we_i,
  input  logic [1:0]              rf_part_i,
  input  logic [$clog2(NACR)-1:0] rf_idx_i,
  input  logic [15:0]             rf_data_i,
  input  logic [$clog2(NACR)-1:0] rf_rd_idx_i,
  input  logic [1:0]              rf_rd_part_i,
  output logic [15:0]             rf_rd_data_o,
  output logic                    flag_z_o,
  output logic                    flag_n_o,
  output logic                    flag_v_o,
  output logic                    flag_s_o,
  input  logic                    clr_sticky_i
);

  localparam int IW = $clog2(NACR);

  typedef enum logic [1:0] {
    PART_LO   = 2'b00,
    PART_HI   = 2'b01,
    PART_GD   = 2'b10,
    PART_FULL = 2'b11
  } part_e;

  logic [39:0]   acc_q [NACR];
  logic [39:0]   acc_d [NACR];
  logic          e2_valid_q, e2_valid_d;
  logic          e2_we_q, e2_we_d;
  logic          e2_fe_q, e2_fe_d;
  logic [IW-1:0] e2_dst_q, e2_dst_d;
  logic          z_q, z_d, n_q, n_d, v_q, v_d, s_q, s_d;

  logic          wb_en;
  logic          flag_en;
  logic [39:0]   rf_merged;
  logic [39:0]   rd_acc;

  // Merge one 16-bit part into the current contents of the RF load target.
  always_comb begin
    rf_merged = acc_q[rf_idx_i];
    unique case (part_e'(rf_part_i))
      PART_LO:   rf_merged[15:0]  = rf_data_i;
      PART_HI:   rf_merged[31:16] = rf_data_i;
      PART_GD:   rf_merged[39:32] = rf_data_i[7:0];
      PART_FULL: rf_merged        = {{8{rf_data_i[15]}}, rf_data_i, 16'h0000};
      default:   rf_merged        = acc_q[rf_idx_i];
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wb_en   = e2_valid_q & e2_we_q;
    flag_en = e2_valid_q & e2_fe_q;
    acc_d   = acc_q;
    // MAC write-back is applied last so it wins a same-index collision with an RF load.
    if (rf_we_i) acc_d[rf_idx_i] = rf_merged;
    if (wb_en)   acc_d[e2_dst_q] = mac_result_i;

    e2_valid_d = iss_valid_i;
    e2_we_d    = iss_valid_i & iss_we_i;
    e2_fe_d    = iss_valid_i & iss_fe_i;
    e2_dst_d   = iss_dst_i;

    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    s_d = clr_sticky_i ? 1'b0 : s_q;
    if (flag_en) begin
      z_d = (mac_result_i == 40'd0);
      n_d = mac_result_i[39];
      v_d = add_pos_overflow_i | add_neg_overflow_i | scale_overflow_i;
      if (sat_flag_i) s_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the accumulator array is architecturally reset, so it is built from flops, not RAM.
      for (int i = 0; i < NACR; i++) acc_q[i] <= '0;
      e2_valid_q <= 1'b0;
      e2_we_q    <= 1'b0;
      e2_fe_q    <= 1'b0;
      e2_dst_q   <= '0;
      z_q        <= 1'b1;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      s_q        <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      e2_valid_q <= e2_valid_d;
      e2_we_q    <= e2_we_d;
      e2_fe_q    <= e2_fe_d;
      e2_dst_q   <= e2_dst_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      s_q        <= s_d;
    end
  end

  // Operands bypass the E2 result so dependent back-to-back MACs need no stall.
  always_comb begin
    mac_operanda_o = (wb_en && rda_idx_i == e2_dst_q) ? mac_result_i : acc_q[rda_idx_i];
    mac_operandb_o = (wb_en && rdb_idx_i == e2_dst_q) ? mac_result_i : acc_q[rdb_idx_i];
  end

  always_comb begin
    rd_acc = acc_q[rf_rd_idx_i];
    unique case (part_e'(rf_rd_part_i))
      PART_LO: rf_rd_data_o = rd_acc[15:0];
      PART_GD: rf_rd_data_o = {{8{rd_acc[39]}}, rd_acc[39:32]};
      default: rf_rd_data_o = rd_acc[31:16];
    endcase
  end

  assign flag_z_o = z_q;
  assign flag_n_o = n_q;
  assign flag_v_o = v_q;
  assign flag_s_o = s_q;

endmodule

// File: tb/tb_mac_acr.sv
// Randomized scoreboard bench for mac_acr against a cycle-level reference model.
module tb_mac_acr;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        iss_valid_i, iss_we_i, iss_fe_i;
  logic [1:0]  iss_dst_i, rda_idx_i, rdb_idx_i;
  logic [39:0] mac_operanda_o, mac_operandb_o, mac_result_i;
  logic        sat_flag_i, scale_overflow_i, add_pos_overflow_i, add_neg_overflow_i;
  logic        rf_we_i;
  logic [1:0]  rf_part_i, rf_idx_i, rf_rd_idx_i, rf_rd_part_i;
  logic [15:0] rf_data_i, rf_rd_data_o;
  logic        flag_z_o, flag_n_o, flag_v_o, flag_s_o, clr_sticky_i;

  always #5 clk = ~clk;

  mac_acr dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .iss_valid_i        (iss_valid_i),
    .iss_we_i           (iss_we_i),
    .iss_fe_i           (iss_fe_i),
    .iss_dst_i          (iss_dst_i),
    .rda_idx_i          (rda_idx_i),
    .rdb_idx_i          (rdb_idx_i),
    .mac_operanda_o     (mac_operanda_o),
    .mac_operandb_o     (mac_operandb_o),
    .mac_result_i       (mac_result_i),
    .sat_flag_i         (sat_flag_i),
    .scale_overflow_i   (scale_overflow_i),
    .add_pos_overflow_i (add_pos_overflow_i),
    .add_neg_overflow_i (add_neg_overflow_i),
    .rf_we_i            (rf_we_i),
    .rf_part_i          (rf_part_i),
    .rf_idx_i           (rf_idx_i),
    .rf_data_i          (rf_data_i),
    .rf_rd_idx_i        (rf_rd_idx_i),
    .rf_rd_part_i       (rf_rd_part_i),
    .rf_rd_data_o       (rf_rd_data_o),
    .flag_z_o           (flag_z_o),
    .flag_n_o           (flag_n_o),
    .flag_v_o           (flag_v_o),
    .flag_s_o           (flag_s_o),
    .clr_sticky_i       (clr_sticky_i)
  );

  typedef struct {
    int          cyc;
    logic [39:0] opa, opb;
    logic [15:0] rd;
    logic        z, n, v, s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: architectural accumulators, flags, and the op waiting for its E2 result.
  logic [39:0] m_acc [4];
  logic        mz, mn, mv, ms;
  logic        known = 1'b0;
  logic        p_valid = 1'b0, p_we = 1'b0, p_fe = 1'b0;
  logic [1:0]  p_dst = 2'd0;

  function automatic logic [15:0] m_read(input logic [39:0] a, input logic [1:0] part);
    case (part)
      2'd0:    return a[15:0];
      2'd2:    return {{8{a[39]}}, a[39:32]};
      default: return a[31:16];
    endcase
  endfunction

  function automatic logic [39:0] m_load(input logic [39:0] a, input logic [1:0] part,
                                         input logic [15:0] d);
    logic [39:0] r;
    r = a;
    case (part)
      2'd0:    r[15:0]  = d;
      2'd1:    r[31:16] = d;
      2'd2:    r[39:32] = d[7:0];
      default: r = {{8{d[15]}}, d, 16'h0000};
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp, input int c);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
  endtask

  task automatic idle();
    iss_valid_i = 0; iss_we_i = 0; iss_fe_i = 0; iss_dst_i = 0;
    rda_idx_i = 0; rdb_idx_i = 0; mac_result_i = '0;
    sat_flag_i = 0; scale_overflow_i = 0; add_pos_overflow_i = 0; add_neg_overflow_i = 0;
    rf_we_i = 0; rf_part_i = 0; rf_idx_i = 0; rf_data_i = '0;
    rf_rd_idx_i = 0; rf_rd_part_i = 0; clr_sticky_i = 0;
  endtask

  // Push this cycle's expectations, clock once, then advance the model with the sampled inputs.
  task automatic step();
    exp_t        e;
    logic        wb;
    wb = p_valid && p_we;
    if (known && !reset_i) begin
      e.cyc = cyc;
      e.opa = (wb && p_dst == rda_idx_i) ? mac_result_i : m_acc[rda_idx_i];
      e.opb = (wb && p_dst == rdb_idx_i) ? mac_result_i : m_acc[rdb_idx_i];
      e.rd  = m_read(m_acc[rf_rd_idx_i], rf_rd_part_i);
      e.z = mz; e.n = mn; e.v = mv; e.s = ms;
      sb.push_back(e);
    end
    @(posedge clk);
    if (reset_i) begin
      for (int i = 0; i < 4; i++) m_acc[i] = '0;
      mz = 1; mn = 0; mv = 0; ms = 0;
      p_valid = 0; p_we = 0; p_fe = 0; p_dst = 0;
      known = 1;
    end else begin
      if (rf_we_i && !(wb && rf_idx_i == p_dst))
        m_acc[rf_idx_i] = m_load(m_acc[rf_idx_i], rf_part_i, rf_data_i);
      if (wb) m_acc[p_dst] = mac_result_i;
      if (clr_sticky_i) ms = 0;
      if (p_valid && p_fe) begin
        mz = (mac_result_i == 40'd0);
        mn = mac_result_i[39];
        mv = add_pos_overflow_i | add_neg_overflow_i | scale_overflow_i;
        if (sat_flag_i) ms = 1;
      end
      p_valid = iss_valid_i; p_we = iss_we_i; p_fe = iss_fe_i; p_dst = iss_dst_i;
    end
    #1;
    cyc++;
  endtask

  task automatic issue(input logic we, input logic fe, input logic [1:0] dst);
    iss_valid_i = 1; iss_we_i = we; iss_fe_i = fe; iss_dst_i = dst;
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("operand_a", mac_operanda_o, e.opa, e.cyc);
      check("operand_b", mac_operandb_o, e.opb, e.cyc);
      check("rf_rd_data", {24'h0, rf_rd_data_o}, {24'h0, e.rd}, e.cyc);
      check("flag_z", {39'h0, flag_z_o}, {39'h0, e.z}, e.cyc);
      check("flag_n", {39'h0, flag_n_o}, {39'h0, e.n}, e.cyc);
      check("flag_v", {39'h0, flag_v_o}, {39'h0, e.v}, e.cyc);
      check("flag_s", {39'h0, flag_s_o}, {39'h0, e.s}, e.cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    idle();
    reset_i = 1;
    step(); step();
    reset_i = 0;

    // Reset state across all indices.
    for (int i = 0; i < 4; i++) begin
      idle(); rda_idx_i = 2'(i); rdb_idx_i = 2'(3 - i); rf_rd_idx_i = 2'(i); step();
    end

    // Full load of 0x8000 into acc1, then read high and guard parts.
    idle(); rf_we_i = 1; rf_part_i = 2'b11; rf_idx_i = 1; rf_data_i = 16'h8000; step();
    idle(); rf_rd_idx_i = 1; rf_rd_part_i = 2'b01; rda_idx_i = 1; step();
    idle(); rf_rd_idx_i = 1; rf_rd_part_i = 2'b10; step();

    // MAC write to acc2 with bypass on both operands during E2.
    idle(); issue(1, 1, 2); step();
    idle(); mac_result_i = 40'h0000012345; rda_idx_i = 2; rdb_idx_i = 2; step();
    idle(); rda_idx_i = 2; rf_rd_idx_i = 2; step();

    // CMP: flags only, zero result with negative add overflow.
    idle(); issue(0, 1, 2); step();
    idle(); mac_result_i = 40'h0; add_neg_overflow_i = 1; rda_idx_i = 2; step();
    idle(); rda_idx_i = 2; step();

    // Sticky saturation: set, hold, clear, clear-with-set.
    idle(); issue(0, 1, 0); step();
    idle(); issue(0, 1, 0); sat_flag_i = 1; mac_result_i = 40'h1; step();
    idle(); mac_result_i = 40'h2; step();
    idle(); clr_sticky_i = 1; step();
    idle(); issue(0, 1, 0); step();
    idle(); clr_sticky_i = 1; sat_flag_i = 1; mac_result_i = 40'h3; step();
    idle(); step();

    // Write collisions: same index drops the RF load; different index lets both proceed.
    idle(); issue(1, 0, 0); step();
    idle(); mac_result_i = 40'h55; rf_we_i = 1; rf_part_i = 0; rf_idx_i = 0; rf_data_i = 16'hAAAA; step();
    idle(); rda_idx_i = 0; rf_rd_idx_i = 0; step();
    idle(); issue(1, 0, 0); step();
    idle(); mac_result_i = 40'h55; rf_we_i = 1; rf_part_i = 0; rf_idx_i = 3; rf_data_i = 16'hAAAA; step();
    idle(); rda_idx_i = 0; rdb_idx_i = 3; rf_rd_idx_i = 3; step();

    // Randomized traffic, including mid-operation resets.
    for (int k = 0; k < 600; k++) begin
      idle();
      reset_i = ($urandom_range(0, 99) == 0);
      iss_valid_i = $urandom_range(0, 2) != 0;
      iss_we_i = $urandom_range(0, 1); iss_fe_i = $urandom_range(0, 1);
      iss_dst_i = 2'($urandom_range(0, 3));
      rda_idx_i = ($urandom_range(0, 1) != 0) ? p_dst : 2'($urandom_range(0, 3));
      rdb_idx_i = ($urandom_range(0, 1) != 0) ? p_dst : 2'($urandom_range(0, 3));
      r = {$urandom, $urandom};
      mac_result_i = ($urandom_range(0, 7) == 0) ? 40'h0 : r[39:0];
      sat_flag_i = ($urandom_range(0, 3) == 0);
      scale_overflow_i = ($urandom_range(0, 5) == 0);
      add_pos_overflow_i = ($urandom_range(0, 5) == 0);
      add_neg_overflow_i = ($urandom_range(0, 5) == 0);
      rf_we_i = ($urandom_range(0, 2) == 0);
      rf_part_i = 2'($urandom_range(0, 3));
      rf_idx_i = ($urandom_range(0, 1) != 0) ? p_dst : 2'($urandom_range(0, 3));
      rf_data_i = 16'($urandom);
      rf_rd_idx_i = 2'($urandom_range(0, 3));
      rf_rd_part_i = 2'($urandom_range(0, 3));
      clr_sticky_i = ($urandom_range(0, 7) == 0);
      step();
    end

    idle(); reset_i = 0;
    step(); step();
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
